// File: rtl/pf_iod_clk_train_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pf_iod_clk_train_pkg
// Description : Shared state encoding, clock-lane patterns and width helper
//               for the IOD clock-training controller.
// Revision    : 1.0 - initial release
// ============================================================================
package pf_iod_clk_train_pkg;

    // Controller state encoding
    localparam logic [3:0] ST_IDLE    = 4'd0;
    localparam logic [3:0] ST_PRESEEK = 4'd1;
    localparam logic [3:0] ST_CLEAR   = 4'd2;
    localparam logic [3:0] ST_SETTLE  = 4'd3;
    localparam logic [3:0] ST_SAMPLE  = 4'd4;
    localparam logic [3:0] ST_EVAL    = 4'd5;
    localparam logic [3:0] ST_STEP    = 4'd6;
    localparam logic [3:0] ST_SEEK    = 4'd7;
    localparam logic [3:0] ST_DONE    = 4'd8;
    localparam logic [3:0] ST_ERR     = 4'd9;

    // A correctly sampled clock lane deserializes to one of these two words
    localparam logic [7:0] CLK_PAT_A = 8'h55;
    localparam logic [7:0] CLK_PAT_B = 8'hAA;

    // Bits needed to index NUM_STEPS phases (ceil(log2(n)))
    function automatic int step_w(input int n);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) w = i + 1;
        end
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pf_iod_clk_train_window.sv
`default_nettype none
// ============================================================================
// Module      : pf_iod_clk_train_window
// Description : Tracks the current and best run of clean phase steps and
//               derives the centre of the best run. Outputs are look-ahead:
//               in a valid cycle they already include the step being scored.
// Revision    : 1.0 - initial release
// ============================================================================
module pf_iod_clk_train_window #(
    parameter int STEP_W = 5
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              clear_i,
    input  logic              valid_i,
    input  logic              clean_i,
    input  logic [STEP_W-1:0] idx_i,
    output logic [STEP_W-1:0] best_start_o,
    output logic [STEP_W:0]   best_len_o,
    output logic [STEP_W:0]   centre_o
);

    logic [STEP_W:0]   cur_len_q,    cur_len_d;
    logic [STEP_W-1:0] cur_start_q,  cur_start_d;
    logic [STEP_W:0]   best_len_q,   best_len_d;
    logic [STEP_W-1:0] best_start_q, best_start_d;
    logic [STEP_W:0]   half_len;

    // Score one step: extend or break the current run, keep the first longest
    always_comb begin
        cur_len_d    = cur_len_q;
        cur_start_d  = cur_start_q;
        best_len_d   = best_len_q;
        best_start_d = best_start_q;
        if (valid_i) begin
            if (clean_i) begin
                if (cur_len_q == '0) cur_start_d = idx_i;
                cur_len_d = cur_len_q + 1'b1;
            end else begin
                cur_len_d = '0;
            end
            if (cur_len_d > best_len_q) begin
                best_len_d   = cur_len_d;
                best_start_d = cur_start_d;
            end
        end
    end

    // Tracker registers; clear starts a fresh sweep
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cur_len_q    <= '0;
            cur_start_q  <= '0;
            best_len_q   <= '0;
            best_start_q <= '0;
        end else if (clear_i) begin
            cur_len_q    <= '0;
            cur_start_q  <= '0;
            best_len_q   <= '0;
            best_start_q <= '0;
        end else begin
            cur_len_q    <= cur_len_d;
            cur_start_q  <= cur_start_d;
            best_len_q   <= best_len_d;
            best_start_q <= best_start_d;
        end
    end

    // Centre rounds toward the start of the run; guarded for an empty run
    assign half_len     = (best_len_d == '0) ? '0 : ((best_len_d - 1'b1) >> 1);
    assign centre_o     = {1'b0, best_start_d} + half_len;
    assign best_len_o   = best_len_d;
    assign best_start_o = best_start_d;

endmodule
`default_nettype wire

// File: rtl/pf_iod_clk_train_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pf_iod_clk_train_ctrl
// Description : Sweeps the HS_IO_CLK phase one step at a time, scores each
//               step from the clock-lane samples and eye-monitor flags, then
//               rotates to the centre of the widest clean window.
// Revision    : 1.0 - initial release
// ============================================================================
module pf_iod_clk_train_ctrl
    import pf_iod_clk_train_pkg::*;
#(
    parameter int  NUM_STEPS  = 32,
    parameter int  SETTLE_CYC = 16,
    parameter int  SAMPLE_CYC = 64,
    parameter int  ROTATE_GAP = 8,
    parameter int  MIN_WINDOW = 4,
    localparam int STEP_W     = step_w(NUM_STEPS)
) (
    input  logic              FAB_CLK,
    input  logic              ARST_N,
    input  logic              TRAIN_START,
    input  logic [7:0]        RX_DATA,
    input  logic              EYE_MONITOR_EARLY,
    input  logic              EYE_MONITOR_LATE,
    output logic              EYE_MONITOR_CLEAR_FLAGS,
    output logic              PHS_ROTATE,
    output logic              PHS_DIRECTION,
    output logic              TRAIN_BUSY,
    output logic              TRAIN_DONE,
    output logic              TRAIN_ERR,
    output logic [STEP_W-1:0] BEST_PHASE,
    output logic [STEP_W:0]   WINDOW_LEN
);

    localparam int                CNT_W     = 16;
    localparam logic [CNT_W-1:0]  SETTLE_LD = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0]  SAMPLE_LD = CNT_W'(SAMPLE_CYC - 1);
    localparam logic [CNT_W-1:0]  GAP_LD    = CNT_W'(ROTATE_GAP);
    localparam logic [STEP_W-1:0] LAST_PH   = STEP_W'(NUM_STEPS - 1);

    logic [3:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [STEP_W-1:0] ph_q, ph_d, ph_inc;
    logic              dirty_q, dirty_d;
    logic              rot_q, rot_d;
    logic              clr_q;
    logic              busy_q;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [STEP_W-1:0] bp_q, bp_d;
    logic [STEP_W:0]   wl_q, wl_d;
    logic              trk_clr, trk_vld, bad_sample;
    logic [STEP_W-1:0] trk_start;
    logic [STEP_W:0]   trk_len, trk_centre;
    logic              unused_trk_start;

    assign ph_inc     = (ph_q == LAST_PH) ? '0 : ph_q + 1'b1;
    assign bad_sample = EYE_MONITOR_EARLY | EYE_MONITOR_LATE |
                        !((RX_DATA == CLK_PAT_A) || (RX_DATA == CLK_PAT_B));
    // Start of the best run is only observed for debug
    assign unused_trk_start = ^trk_start;

    pf_iod_clk_train_window #(
        .STEP_W (STEP_W)
    ) u_window (
        .clk_i        (FAB_CLK),
        .rst_n_i      (ARST_N),
        .clear_i      (trk_clr),
        .valid_i      (trk_vld),
        .clean_i      (!dirty_q),
        .idx_i        (ph_q),
        .best_start_o (trk_start),
        .best_len_o   (trk_len),
        .centre_o     (trk_centre)
    );

    // Sequencing: every rotate is a one-cycle pulse followed by ROTATE_GAP idle cycles
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ph_d    = ph_q;
        dirty_d = dirty_q;
        rot_d   = 1'b0;
        done_d  = done_q;
        err_d   = err_q;
        bp_d    = bp_q;
        wl_d    = wl_q;
        trk_clr = 1'b0;
        trk_vld = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (TRAIN_START) begin
                    state_d = ST_PRESEEK;
                    cnt_d   = '0;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    trk_clr = 1'b1;
                end
            end
            ST_PRESEEK: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (ph_q == '0) begin
                    state_d = ST_CLEAR;
                end else begin
                    rot_d = 1'b1;
                    ph_d  = ph_inc;
                    cnt_d = GAP_LD;
                end
            end
            ST_CLEAR: begin
                state_d = ST_SETTLE;
                cnt_d   = SETTLE_LD;
            end
            ST_SETTLE: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    state_d = ST_SAMPLE;
                    cnt_d   = SAMPLE_LD;
                    dirty_d = 1'b0;
                end
            end
            ST_SAMPLE: begin
                dirty_d = dirty_q | bad_sample;
                if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
                else             state_d = ST_EVAL;
            end
            ST_EVAL: begin
                trk_vld = 1'b1;
                if (ph_q != LAST_PH) begin
                    state_d = ST_STEP;
                    rot_d   = 1'b1;
                    ph_d    = ph_inc;
                    cnt_d   = GAP_LD;
                end else if (int'(trk_len) < MIN_WINDOW) begin
                    state_d = ST_ERR;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    bp_d    = '0;
                    wl_d    = trk_len;
                end else if (trk_centre == {1'b0, ph_q}) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    bp_d    = trk_centre[STEP_W-1:0];
                    wl_d    = trk_len;
                end else begin
                    state_d = ST_SEEK;
                    rot_d   = 1'b1;
                    ph_d    = ph_inc;
                    cnt_d   = GAP_LD;
                end
            end
            ST_STEP: begin
                if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
                else             state_d = ST_CLEAR;
            end
            ST_SEEK: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (trk_centre == {1'b0, ph_q}) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    bp_d    = trk_centre[STEP_W-1:0];
                    wl_d    = trk_len;
                end else begin
                    rot_d = 1'b1;
                    ph_d  = ph_inc;
                    cnt_d = GAP_LD;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, phase index and registered outputs
    always_ff @(posedge FAB_CLK or negedge ARST_N) begin
        if (!ARST_N) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            ph_q    <= '0;
            dirty_q <= 1'b0;
            rot_q   <= 1'b0;
            clr_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            bp_q    <= '0;
            wl_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ph_q    <= ph_d;
            dirty_q <= dirty_d;
            rot_q   <= rot_d;
            clr_q   <= (state_d == ST_CLEAR);
            busy_q  <= !((state_d == ST_IDLE) || (state_d == ST_DONE) || (state_d == ST_ERR));
            done_q  <= done_d;
            err_q   <= err_d;
            bp_q    <= bp_d;
            wl_q    <= wl_d;
        end
    end

    assign EYE_MONITOR_CLEAR_FLAGS = clr_q;
    assign PHS_ROTATE              = rot_q;
    assign PHS_DIRECTION           = 1'b1;
    assign TRAIN_BUSY              = busy_q;
    assign TRAIN_DONE              = done_q;
    assign TRAIN_ERR               = err_q;
    assign BEST_PHASE              = bp_q;
    assign WINDOW_LEN              = wl_q;

endmodule
`default_nettype wire

// File: tb/tb_pf_iod_clk_train_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_pf_iod_clk_train_ctrl
// Description : Self-checking bench: per-phase clean/dirty plans with random
//               glitch placement, compared against a run-length reference.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pf_iod_clk_train_ctrl;

    localparam int N    = 32;
    localparam int S    = 6;
    localparam int M    = 10;
    localparam int G    = 3;
    localparam int MINW = 4;
    localparam int SW   = 5;

    logic          FAB_CLK = 1'b0;
    logic          ARST_N = 1'b0;
    logic          TRAIN_START = 1'b0;
    logic [7:0]    RX_DATA = 8'h55;
    logic          EARLY = 1'b0;
    logic          LATE = 1'b0;
    logic          CLR_FLAGS, PHS_ROTATE, PHS_DIRECTION;
    logic          TRAIN_BUSY, TRAIN_DONE, TRAIN_ERR;
    logic [SW-1:0] BEST_PHASE;
    logic [SW:0]   WINDOW_LEN;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] mask = '0;
    bit          force_5a = 1'b0;
    int          tb_ph = 0;

    int drv_ph = 0;
    int drv_pos = 1000;
    int glitch_at = -1;
    int kind = 0;

    pf_iod_clk_train_ctrl #(
        .NUM_STEPS  (N),
        .SETTLE_CYC (S),
        .SAMPLE_CYC (M),
        .ROTATE_GAP (G),
        .MIN_WINDOW (MINW)
    ) dut (
        .FAB_CLK                 (FAB_CLK),
        .ARST_N                  (ARST_N),
        .TRAIN_START             (TRAIN_START),
        .RX_DATA                 (RX_DATA),
        .EYE_MONITOR_EARLY       (EARLY),
        .EYE_MONITOR_LATE        (LATE),
        .EYE_MONITOR_CLEAR_FLAGS (CLR_FLAGS),
        .PHS_ROTATE              (PHS_ROTATE),
        .PHS_DIRECTION           (PHS_DIRECTION),
        .TRAIN_BUSY              (TRAIN_BUSY),
        .TRAIN_DONE              (TRAIN_DONE),
        .TRAIN_ERR               (TRAIN_ERR),
        .BEST_PHASE              (BEST_PHASE),
        .WINDOW_LEN              (WINDOW_LEN)
    );

    always #5 FAB_CLK = ~FAB_CLK;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] bad_byte();
        logic [7:0] b;
        do b = 8'($urandom); while (b == 8'h55 || b == 8'hAA);
        return b;
    endfunction

    // Longest run of set bits over 0..N-1 (no wrap); first one wins on a tie
    function automatic void ref_best(input logic [31:0] m, output int blen, output int bstart);
        blen = 0;
        bstart = 0;
        for (int s = 0; s < N; s++) begin
            int len = 0;
            while (s + len < N && m[s + len]) len++;
            if (len > blen) begin
                blen = len;
                bstart = s;
            end
        end
    endfunction

    // Lane stimulus: position within each step is counted from the clear pulse
    always @(negedge FAB_CLK) begin
        if (!ARST_N) begin
            drv_ph = 0;
            drv_pos = 1000;
            glitch_at = -1;
        end else begin
            if (PHS_ROTATE) drv_ph = (drv_ph + 1) % N;
            if (CLR_FLAGS) begin
                drv_pos = 0;
                kind = $urandom_range(0, 2);
                if (mask[drv_ph]) begin
                    case ($urandom_range(0, 3))
                        0:       glitch_at = -1;
                        1:       glitch_at = $urandom_range(0, S);
                        2:       glitch_at = S;
                        default: glitch_at = S + M + 1;
                    endcase
                end else begin
                    case ($urandom_range(0, 2))
                        0:       glitch_at = S + 1;
                        1:       glitch_at = S + M;
                        default: glitch_at = $urandom_range(S + 1, S + M);
                    endcase
                end
            end else if (drv_pos < 1000) begin
                drv_pos++;
            end
        end
        RX_DATA = $urandom_range(0, 1) ? 8'h55 : 8'hAA;
        EARLY = 1'b0;
        LATE = 1'b0;
        if (drv_pos == glitch_at) begin
            if (force_5a) RX_DATA = 8'h5A;
            else begin
                case (kind)
                    0:       EARLY = 1'b1;
                    1:       LATE = 1'b1;
                    default: RX_DATA = bad_byte();
                endcase
            end
        end
    end

    task automatic run_train(input logic [31:0] m, input bit poke, input string nm);
        int pre = 0, swp = 0, seek = 0, clears = 0, cyc = 0;
        int last_pulse = -1000, last_clr = -1, min_sp = 1000, sp_bad = 0, done_cyc = -1;
        int blen, bstart, centre, exp_seek, exp_bp;
        bit exp_err, poked = 0;
        mask = m;
        TRAIN_START = 1'b1;
        @(negedge FAB_CLK);
        TRAIN_START = 1'b0;
        check_eq({nm, "_busy_rise"}, 32'(TRAIN_BUSY), 1);
        check_eq({nm, "_done_cleared"}, 32'(TRAIN_DONE), 0);
        while (done_cyc < 0 && cyc < 4000) begin
            if (PHS_ROTATE) begin
                if (clears == 0) pre++;
                else if (clears < N) swp++;
                else seek++;
                if (cyc - last_pulse < min_sp) min_sp = cyc - last_pulse;
                last_pulse = cyc;
            end
            if (CLR_FLAGS) begin
                if (last_clr >= 0 && cyc - last_clr != S + M + G + 3) sp_bad++;
                last_clr = cyc;
                clears++;
            end
            if (TRAIN_DONE) done_cyc = cyc;
            if (poke && !poked && clears == 8 && cyc - last_clr == S + 3) begin
                TRAIN_START = 1'b1;
                poked = 1'b1;
            end else begin
                TRAIN_START = 1'b0;
            end
            cyc++;
            @(negedge FAB_CLK);
        end
        TRAIN_START = 1'b0;
        check_eq({nm, "_completed"}, 32'(done_cyc >= 0), 1);

        ref_best(m, blen, bstart);
        exp_err  = (blen < MINW);
        centre   = bstart + (blen > 0 ? (blen - 1) / 2 : 0);
        exp_seek = exp_err ? 0 : (centre + 1) % N;
        exp_bp   = exp_err ? 0 : centre;

        check_eq({nm, "_preseek_rot"}, pre, (N - tb_ph) % N);
        check_eq({nm, "_sweep_rot"}, swp, N - 1);
        check_eq({nm, "_steps"}, clears, N);
        check_eq({nm, "_step_len"}, sp_bad, 0);
        check_eq({nm, "_seek_rot"}, seek, exp_seek);
        check_eq({nm, "_rot_spacing"}, 32'(min_sp >= G + 1), 1);
        check_eq({nm, "_err"}, 32'(TRAIN_ERR), 32'(exp_err));
        check_eq({nm, "_best_phase"}, 32'(BEST_PHASE), exp_bp);
        check_eq({nm, "_window_len"}, 32'(WINDOW_LEN), blen);
        check_eq({nm, "_busy_fall"}, 32'(TRAIN_BUSY), 0);
        if (exp_seek > 0) check_eq({nm, "_done_lat"}, done_cyc - last_pulse, G + 1);
        else              check_eq({nm, "_done_lat"}, done_cyc - last_clr, S + M + 2);
        tb_ph = exp_err ? N - 1 : centre;
    endtask

    task automatic check_reset_vals(input string nm);
        check_eq({nm, "_busy"}, 32'(TRAIN_BUSY), 0);
        check_eq({nm, "_done"}, 32'(TRAIN_DONE), 0);
        check_eq({nm, "_err"}, 32'(TRAIN_ERR), 0);
        check_eq({nm, "_rot"}, 32'(PHS_ROTATE), 0);
        check_eq({nm, "_clrflags"}, 32'(CLR_FLAGS), 0);
        check_eq({nm, "_dir"}, 32'(PHS_DIRECTION), 1);
        check_eq({nm, "_best_phase"}, 32'(BEST_PHASE), 0);
        check_eq({nm, "_window_len"}, 32'(WINDOW_LEN), 0);
    endtask

    task automatic reset_mid();
        int clears = 0, cyc = 0, last_clr = -1;
        bit hit = 0;
        mask = $urandom;
        TRAIN_START = 1'b1;
        @(negedge FAB_CLK);
        TRAIN_START = 1'b0;
        while (!hit && cyc < 4000) begin
            if (CLR_FLAGS) begin
                clears++;
                last_clr = cyc;
            end
            if (clears == 8 && cyc - last_clr == S + 4) hit = 1'b1;
            else begin
                cyc++;
                @(negedge FAB_CLK);
            end
        end
        check_eq("rst_mid_reached", 32'(hit), 1);
        check_eq("rst_mid_busy_before", 32'(TRAIN_BUSY), 1);
        ARST_N = 1'b0;
        #1;
        check_reset_vals("rst_mid");
        @(negedge FAB_CLK);
        @(negedge FAB_CLK);
        ARST_N = 1'b1;
        @(negedge FAB_CLK);
        check_eq("rst_mid_idle_after", 32'(TRAIN_BUSY), 0);
        tb_ph = 0;
    endtask

    initial begin
        ARST_N = 1'b0;
        repeat (3) @(negedge FAB_CLK);
        check_reset_vals("por");
        ARST_N = 1'b1;
        @(negedge FAB_CLK);

        run_train(32'h000F_FC00, 1'b0, "win10_19");
        check_eq("win10_19_bp_const", 32'(BEST_PHASE), 14);

        force_5a = 1'b1;
        run_train(32'h03F0_01F8, 1'b0, "tie_5a");
        force_5a = 1'b0;
        check_eq("tie_5a_bp_const", 32'(BEST_PHASE), 5);

        run_train(32'hFFFF_FFFF, 1'b0, "all_clean");
        check_eq("all_clean_wl_const", 32'(WINDOW_LEN), 32);

        run_train(32'h0000_0007, 1'b0, "short_err");
        check_eq("short_err_done", 32'(TRAIN_DONE), 1);

        run_train(32'h000F_FC00, 1'b1, "poke_start");
        run_train(32'h000F_FC00, 1'b0, "rerun_from14");

        reset_mid();
        run_train($urandom | $urandom, 1'b0, "after_rst");

        for (int r = 0; r < 5; r++) begin
            logic [31:0] m;
            case (r % 3)
                0:       m = $urandom | $urandom;
                1:       m = $urandom & $urandom;
                default: m = $urandom;
            endcase
            run_train(m, 1'b0, $sformatf("rand%0d", r));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
